ddr_init_seq: RTL and testbench



---
 rtl/ddr_init_seq_if.sv | 35 +++
 rtl/ddr_init_seq.sv | 185 ++++++++++++++++++
 tb/tb_ddr_init_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_init_seq_if.sv
// Control and DFI command bus of the DDR3 power-up init sequencer.
// The master modport is the sequencer side; the slave modport is the core/DFI side.
interface ddr_init_seq_if #(
    parameter int ADDR_W = 16,
    parameter int BANK_W = 3
);
    logic              ddr_init_start;
    logic              ddr_init_restart;
    logic [ADDR_W-1:0] mr0;
    logic [ADDR_W-1:0] mr1;
    logic [ADDR_W-1:0] mr2;
    logic [ADDR_W-1:0] mr3;
    logic              ddr_init_done;
    logic              ddr_init_busy;
    logic              dfi_reset_n;
    logic              dfi_cke;
    logic              dfi_cs_n;
    logic              dfi_ras_n;
    logic              dfi_cas_n;
    logic              dfi_we_n;
    logic [BANK_W-1:0] dfi_bank;
    logic [ADDR_W-1:0] dfi_address;

    modport master (
        input  ddr_init_start, ddr_init_restart, mr0, mr1, mr2, mr3,
        output ddr_init_done, ddr_init_busy, dfi_reset_n, dfi_cke,
               dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address
    );

    modport slave (
        output ddr_init_start, ddr_init_restart, mr0, mr1, mr2, mr3,
        input  ddr_init_done, ddr_init_busy, dfi_reset_n, dfi_cke,
               dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address
    );
endinterface

// File: rtl/ddr_init_seq.sv
// DDR3 JEDEC power-up sequencer: RESET#, CKE, tXPR, MR2/MR3/MR1/MR0, ZQCL, tZQinit.
// All outputs are registered and decoded from the next state.
module ddr_init_seq #(
    parameter int CLK_PERIOD_PS = 2500,
    parameter int T_RESET_NS    = 200000,
    parameter int T_CKE_NS      = 500000,
    parameter int T_XPR_CK      = 5,
    parameter int T_MRD_CK      = 4,
    parameter int T_MOD_CK      = 12,
    parameter int T_ZQINIT_CK   = 512,
    parameter int ADDR_W        = 16,
    parameter int BANK_W        = 3,
    parameter int CNT_W         = 20
) (
    input  logic           core_clk,
    input  logic           core_arstn,
    ddr_init_seq_if.master bus
);
    localparam longint N_RESET = (longint'(T_RESET_NS) * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
    localparam longint N_CKE   = (longint'(T_CKE_NS) * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(N_RESET - 1);
    localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(N_CKE - 1);
    localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR_CK - 1);
    localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD_CK - 2);
    localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(T_MOD_CK - 2);
    localparam logic [CNT_W-1:0] LD_ZQ    = CNT_W'(T_ZQINIT_CK - 2);

    if (N_RESET - 1 > CNT_MAX || N_CKE - 1 > CNT_MAX || longint'(T_XPR_CK) - 1 > CNT_MAX ||
        longint'(T_MOD_CK) - 1 > CNT_MAX || longint'(T_ZQINIT_CK) - 1 > CNT_MAX ||
        longint'(T_MRD_CK) - 1 > CNT_MAX) begin : g_cnt_check
        $error("ddr_init_seq: a derived delay count does not fit in CNT_W bits");
    end
    if (ADDR_W < 11 || T_XPR_CK < 1 || T_MRD_CK < 1 || T_MOD_CK < 1 || T_ZQINIT_CK < 1) begin : g_param_check
        $error("ddr_init_seq: ADDR_W must be >= 11 and all clock delays >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_RESET_HOLD, S_CKE_WAIT, S_XPR_WAIT, S_MRS,
        S_MRD_WAIT, S_MOD_WAIT, S_ZQCL, S_ZQ_WAIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic              reset_n_q, reset_n_d;
    logic              cke_q, cke_d;
    logic              cs_n_q, cs_n_d;
    logic              ras_n_q, ras_n_d;
    logic              cas_n_q, cas_n_d;
    logic              we_n_q, we_n_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

        case (state_q)
            S_IDLE: if (bus.ddr_init_start) begin
                state_d = S_RESET_HOLD;
                cnt_d   = LD_RESET;
            end
            S_RESET_HOLD: if (cnt_q == '0) begin
                state_d = S_CKE_WAIT;
                cnt_d   = LD_CKE;
            end
            S_CKE_WAIT: if (cnt_q == '0) begin
                state_d = S_XPR_WAIT;
                cnt_d   = LD_XPR;
            end
            S_XPR_WAIT: if (cnt_q == '0) begin
                state_d = S_MRS;
                idx_d   = 2'd0;
            end
            S_MRS: begin
                if (idx_q == 2'd3) begin
                    if (T_MOD_CK > 1) begin
                        state_d = S_MOD_WAIT;
                        cnt_d   = LD_MOD;
                    end else begin
                        state_d = S_ZQCL;
                    end
                end else if (T_MRD_CK > 1) begin
                    state_d = S_MRD_WAIT;
                    cnt_d   = LD_MRD;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_MRD_WAIT: if (cnt_q == '0) begin
                state_d = S_MRS;
                idx_d   = idx_q + 2'd1;
            end
            S_MOD_WAIT: if (cnt_q == '0) state_d = S_ZQCL;
            S_ZQCL: begin
                if (T_ZQINIT_CK > 1) begin
                    state_d = S_ZQ_WAIT;
                    cnt_d   = LD_ZQ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ZQ_WAIT: if (cnt_q == '0) state_d = S_DONE;
            S_DONE: if (bus.ddr_init_restart) begin
                state_d = S_RESET_HOLD;
                cnt_d   = LD_RESET;
            end
            default: state_d = S_IDLE;
        endcase

        // Output decode looks at the next state so changes appear on state entry.
        reset_n_d = !(state_d == S_IDLE || state_d == S_RESET_HOLD);
        cke_d     = !(state_d == S_IDLE || state_d == S_RESET_HOLD || state_d == S_CKE_WAIT);
        done_d    = (state_d == S_DONE);
        busy_d    = !(state_d == S_IDLE || state_d == S_DONE);
        cs_n_d    = !cke_d;
        ras_n_d   = 1'b1;
        cas_n_d   = 1'b1;
        we_n_d    = 1'b1;
        bank_d    = '0;
        addr_d    = '0;
        if (state_d == S_MRS) begin
            ras_n_d = 1'b0;
            cas_n_d = 1'b0;
            we_n_d  = 1'b0;
            case (idx_d)
                2'd0:    begin bank_d = BANK_W'(2); addr_d = bus.mr2; end
                2'd1:    begin bank_d = BANK_W'(3); addr_d = bus.mr3; end
                2'd2:    begin bank_d = BANK_W'(1); addr_d = bus.mr1; end
                default: begin bank_d = BANK_W'(0); addr_d = bus.mr0; end
            endcase
        end else if (state_d == S_ZQCL) begin
            we_n_d     = 1'b0;
            addr_d[10] = 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            reset_n_q <= 1'b0;
            cke_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            ras_n_q   <= 1'b1;
            cas_n_q   <= 1'b1;
            we_n_q    <= 1'b1;
            bank_q    <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            reset_n_q <= reset_n_d;
            cke_q     <= cke_d;
            cs_n_q    <= cs_n_d;
            ras_n_q   <= ras_n_d;
            cas_n_q   <= cas_n_d;
            we_n_q    <= we_n_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.dfi_reset_n   = reset_n_q;
    assign bus.dfi_cke       = cke_q;
    assign bus.dfi_cs_n      = cs_n_q;
    assign bus.dfi_ras_n     = ras_n_q;
    assign bus.dfi_cas_n     = cas_n_q;
    assign bus.dfi_we_n      = we_n_q;
    assign bus.dfi_bank      = bank_q;
    assign bus.dfi_address   = addr_q;
    assign bus.ddr_init_done = done_q;
    assign bus.ddr_init_busy = busy_q;
endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: three instances cover base timing, T_MRD_CK=1 and a 1500 ps clock.
// Output vector: {done, busy, reset_n, cke, cs_n, ras_n, cas_n, we_n, bank[2:0], address[15:0]}.
module tb_ddr_init_seq;
    localparam logic [15:0] MR0_V = 16'h0d70;
    localparam logic [15:0] MR1_V = 16'h0044;
    localparam logic [15:0] MR2_V = 16'h0218;
    localparam logic [15:0] MR3_V = 16'h0004;
    localparam logic [26:0] RST_V = 27'h0780000;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic st [3];
    logic rs [3];
    int   nvec = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    ddr_init_seq_if #(.ADDR_W(16), .BANK_W(3)) ifa ();
    ddr_init_seq_if #(.ADDR_W(16), .BANK_W(3)) ifb ();
    ddr_init_seq_if #(.ADDR_W(16), .BANK_W(3)) ifc ();

    assign ifa.ddr_init_start = st[0];  assign ifa.ddr_init_restart = rs[0];
    assign ifb.ddr_init_start = st[1];  assign ifb.ddr_init_restart = rs[1];
    assign ifc.ddr_init_start = st[2];  assign ifc.ddr_init_restart = rs[2];
    assign ifa.mr0 = MR0_V; assign ifa.mr1 = MR1_V; assign ifa.mr2 = MR2_V; assign ifa.mr3 = MR3_V;
    assign ifb.mr0 = MR0_V; assign ifb.mr1 = MR1_V; assign ifb.mr2 = MR2_V; assign ifb.mr3 = MR3_V;
    assign ifc.mr0 = MR0_V; assign ifc.mr1 = MR1_V; assign ifc.mr2 = MR2_V; assign ifc.mr3 = MR3_V;

    ddr_init_seq #(.CLK_PERIOD_PS(1000), .T_RESET_NS(20), .T_CKE_NS(50), .T_XPR_CK(5),
                   .T_MRD_CK(4), .T_MOD_CK(12), .T_ZQINIT_CK(512))
        dut_a (.core_clk(clk), .core_arstn(arstn), .bus(ifa));
    ddr_init_seq #(.CLK_PERIOD_PS(1000), .T_RESET_NS(20), .T_CKE_NS(50), .T_XPR_CK(5),
                   .T_MRD_CK(1), .T_MOD_CK(12), .T_ZQINIT_CK(512))
        dut_b (.core_clk(clk), .core_arstn(arstn), .bus(ifb));
    ddr_init_seq #(.CLK_PERIOD_PS(1500), .T_RESET_NS(20), .T_CKE_NS(50), .T_XPR_CK(5),
                   .T_MRD_CK(4), .T_MOD_CK(12), .T_ZQINIT_CK(512))
        dut_c (.core_clk(clk), .core_arstn(arstn), .bus(ifc));

    function automatic logic [26:0] obs(input int d);
        case (d)
            0: return {ifa.ddr_init_done, ifa.ddr_init_busy, ifa.dfi_reset_n, ifa.dfi_cke, ifa.dfi_cs_n,
                       ifa.dfi_ras_n, ifa.dfi_cas_n, ifa.dfi_we_n, ifa.dfi_bank, ifa.dfi_address};
            1: return {ifb.ddr_init_done, ifb.ddr_init_busy, ifb.dfi_reset_n, ifb.dfi_cke, ifb.dfi_cs_n,
                       ifb.dfi_ras_n, ifb.dfi_cas_n, ifb.dfi_we_n, ifb.dfi_bank, ifb.dfi_address};
            default: return {ifc.ddr_init_done, ifc.ddr_init_busy, ifc.dfi_reset_n, ifc.dfi_cke, ifc.dfi_cs_n,
                       ifc.dfi_ras_n, ifc.dfi_cas_n, ifc.dfi_we_n, ifc.dfi_bank, ifc.dfi_address};
        endcase
    endfunction

    // Expected outputs t cycles after the edge that accepted start/restart (t=1 is right after it).
    function automatic logic [26:0] expv(input int t, input int nrst, input int ncke, input int mrd);
        int c, m0, z, dn;
        logic [26:0] v;
        c  = nrst + ncke + 1;
        m0 = c + 5;
        z  = m0 + 3 * mrd + 12;
        dn = z + 512;
        v  = '0;
        v[26] = (t >= dn);
        v[25] = (t < dn);
        v[24] = (t > nrst);
        v[23] = (t >= c);
        v[22:19] = (t >= c) ? 4'b0111 : 4'b1111;
        if (t == m0)           begin v[22:19] = 4'b0000; v[18:16] = 3'd2; v[15:0] = MR2_V; end
        if (t == m0 + mrd)     begin v[22:19] = 4'b0000; v[18:16] = 3'd3; v[15:0] = MR3_V; end
        if (t == m0 + 2 * mrd) begin v[22:19] = 4'b0000; v[18:16] = 3'd1; v[15:0] = MR1_V; end
        if (t == m0 + 3 * mrd) begin v[22:19] = 4'b0000; v[18:16] = 3'd0; v[15:0] = MR0_V; end
        if (t == z)            begin v[22:19] = 4'b0110; v[15:0] = 16'h0400; end
        return v;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin st[i] = 1'b0; rs[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            nvec++;
            if (obs(d) !== RST_V) begin
                nfail++;
                $display("FAIL reset_values dut=%0d got=%h exp=%h", d, obs(d), RST_V);
            end
        end
        arstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                nvec++;
                if (obs(d) !== RST_V) begin
                    nfail++;
                    $display("FAIL idle_no_start dut=%0d cyc=%0d got=%h exp=%h", d, c, obs(d), RST_V);
                end
            end
        end
    endtask

    task automatic test_full_sequence();
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        for (int t = 1; t <= 614; t++) begin
            nvec++;
            if (obs(0) !== expv(t, 20, 50, 4)) begin
                nfail++;
                $display("FAIL full_seq t=%0d got=%h exp=%h", t, obs(0), expv(t, 20, 50, 4));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_restart();
        nvec++;
        if (obs(0) !== expv(615, 20, 50, 4)) begin
            nfail++;
            $display("FAIL restart_pre_done got=%h exp=%h", obs(0), expv(615, 20, 50, 4));
        end
        rs[0] = 1'b1;
        @(posedge clk); #1;
        rs[0] = 1'b0;
        nvec++;
        if ({ifa.ddr_init_done, ifa.dfi_reset_n, ifa.dfi_cke} !== 3'b000) begin
            nfail++;
            $display("FAIL restart_drop got=%b exp=000", {ifa.ddr_init_done, ifa.dfi_reset_n, ifa.dfi_cke});
        end
        for (int t = 1; t <= 615; t++) begin
            nvec++;
            if (obs(0) !== expv(t, 20, 50, 4)) begin
                nfail++;
                $display("FAIL restart_seq t=%0d got=%h exp=%h", t, obs(0), expv(t, 20, 50, 4));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_arst_mid();
        arstn = 1'b0;
        #2 arstn = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        for (int t = 1; t <= 82; t++) begin
            nvec++;
            if (obs(0) !== expv(t, 20, 50, 4)) begin
                nfail++;
                $display("FAIL arst_pre t=%0d got=%h exp=%h", t, obs(0), expv(t, 20, 50, 4));
            end
            if (t < 82) begin @(posedge clk); #1; end
        end
        #1 arstn = 1'b0;
        #1;
        nvec++;
        if (obs(0) !== RST_V) begin
            nfail++;
            $display("FAIL arst_async got=%h exp=%h", obs(0), RST_V);
        end
        #1 arstn = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            nvec++;
            if (obs(0) !== RST_V) begin
                nfail++;
                $display("FAIL arst_idle cyc=%0d got=%h exp=%h", c, obs(0), RST_V);
            end
        end
    endtask

    task automatic test_start_held();
        st[0] = 1'b1;
        @(posedge clk); #1;
        for (int t = 1; t <= 632; t++) begin
            nvec++;
            if (obs(0) !== expv(t, 20, 50, 4)) begin
                nfail++;
                $display("FAIL start_held t=%0d got=%h exp=%h", t, obs(0), expv(t, 20, 50, 4));
            end
            rs[0] = ((t >= 30 && t < 40) || (t >= 300 && t < 305)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        st[0] = 1'b0;
        rs[0] = 1'b0;
    endtask

    task automatic test_mrd1();
        st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        for (int t = 1; t <= 606; t++) begin
            nvec++;
            if (obs(1) !== expv(t, 20, 50, 1)) begin
                nfail++;
                $display("FAIL mrd1_seq t=%0d got=%h exp=%h", t, obs(1), expv(t, 20, 50, 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clk1500();
        st[2] = 1'b1;
        @(posedge clk); #1;
        st[2] = 1'b0;
        for (int t = 1; t <= 593; t++) begin
            nvec++;
            if (obs(2) !== expv(t, 14, 34, 4)) begin
                nfail++;
                $display("FAIL clk1500_seq t=%0d got=%h exp=%h", t, obs(2), expv(t, 14, 34, 4));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_restart();
        test_arst_mid();
        test_start_held();
        test_mrd1();
        test_clk1500();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
